// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the Nios II debug command bridge.
// Holds the FSM state encoding, default parameter values and the action-flag position helper.
package nios_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } dbg_state_e;

    localparam int DEF_IR_W        = 2;
    localparam int DEF_DR_W        = 38;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_ACK_TIMEOUT = 255;

    // The top bit of the DR snapshot tells action from no-action commands.
    function automatic int action_bit(input int dr_w);
        return dr_w - 1;
    endfunction

endpackage

// File: rtl/nios_dbg_toggle_sync.sv
// Brings a TCK-side toggle into clk and flags each level change as a one-cycle event.
// The flops have no reset, so a level held through reset never looks like an event.
module nios_dbg_toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_tgl,
    output logic o_event
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge i_clk) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_tgl};
        r_hist <= r_sync[SYNC_STAGES-1];
    end

    assign o_event = r_sync[SYNC_STAGES-1] ^ r_hist;

endmodule

// File: rtl/nios_dbg_cmd_bridge.sv
// System-clock side of the JTAG debug slave: synchronises update events, decodes the
// latched command onto one channel and tracks the ack handshake with overrun/timeout flags.
module nios_dbg_cmd_bridge
    import nios_dbg_pkg::*;
#(
    parameter int IR_W        = DEF_IR_W,
    parameter int DR_W        = DEF_DR_W,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DR_W-1:0]   sr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              uir_tgl,
    input  logic              udr_tgl,
    input  logic [NUM_CH-1:0] ch_ack,
    input  logic              err_clr,
    output logic [DR_W-1:0]   jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic              st_ready,
    output logic              busy,
    output logic              overrun_err,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int FLAG  = action_bit(DR_W);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_CAPTURE  = ST_CAPTURE;
    localparam logic [1:0] S_ISSUE    = ST_ISSUE;
    localparam logic [1:0] S_WAIT_ACK = ST_WAIT_ACK;

    logic              w_uir_evt;
    logic              w_udr_evt;
    logic [NUM_CH-1:0] w_ch_sel;
    logic              w_ack;
    logic              w_tmo_hit;
    logic              w_ovr_set;
    logic              w_tmo_set;

    logic [1:0]        r_state;
    logic [IR_W-1:0]   r_ir_q;
    logic [IR_W-1:0]   r_ch_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [DR_W-1:0]   r_jdo;
    logic [NUM_CH-1:0] r_act;
    logic [NUM_CH-1:0] r_noact;
    logic              r_ovr;
    logic              r_tmo;

    nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .i_clk   (clk),
        .i_tgl   (uir_tgl),
        .o_event (w_uir_evt)
    );

    nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .i_clk   (clk),
        .i_tgl   (udr_tgl),
        .o_event (w_udr_evt)
    );

    assign w_ch_sel  = NUM_CH'(1) << r_ch_q;
    assign w_ack     = |(ch_ack & w_ch_sel);
    assign w_tmo_hit = (r_cnt == CNT_W'(ACK_TIMEOUT));
    assign w_ovr_set = w_udr_evt && (r_state != S_IDLE);
    // An ack arriving on the timeout cycle suppresses the error.
    assign w_tmo_set = (r_state == S_WAIT_ACK) && !w_ack && w_tmo_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ir_q  <= '0;
            r_ch_q  <= '0;
            r_cnt   <= '0;
            r_jdo   <= '0;
            r_act   <= '0;
            r_noact <= '0;
            r_ovr   <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_act   <= '0;
            r_noact <= '0;

            if (w_uir_evt) r_ir_q <= ir_in;

            if (w_ovr_set)    r_ovr <= 1'b1;
            else if (err_clr) r_ovr <= 1'b0;

            if (w_tmo_set)    r_tmo <= 1'b1;
            else if (err_clr) r_tmo <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_udr_evt) r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_jdo   <= sr;
                    r_ch_q  <= r_ir_q;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (r_jdo[FLAG]) begin
                        r_act   <= w_ch_sel;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_ACK;
                    end else begin
                        r_noact <= w_ch_sel;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_ACK: begin
                    // Leaving at the limit keeps the counter from ever wrapping.
                    if (w_ack || w_tmo_hit) r_state <= S_IDLE;
                    else                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign jdo            = r_jdo;
    assign take_action    = r_act;
    assign take_no_action = r_noact;
    assign st_ready       = (r_state == S_IDLE);
    assign busy           = ~st_ready;
    assign overrun_err    = r_ovr;
    assign timeout_err    = r_tmo;

endmodule
